// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC core.
// CORDIC_GAIN_COMP_EN selects the optional gain-compensation stage in the core.
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROTATE,
    ST_SCALE,
    ST_DONE
  } state_t;

  localparam int XY_FRAC = 13;  // x/y are Q2.13
  localparam int Z_FRAC  = 12;  // z is Q3.12
  localparam int LUT_W   = 16;

  // 1/K = 0.60725 in Q2.13
  localparam logic [15:0] INV_GAIN = 16'd4975;

  // round(atan(2^-i) * 2^Z_FRAC)
  function automatic logic [LUT_W-1:0] atan_lut(input logic [3:0] i);
    case (i)
      4'd0:    atan_lut = 16'd3217;
      4'd1:    atan_lut = 16'd1899;
      4'd2:    atan_lut = 16'd1003;
      4'd3:    atan_lut = 16'd509;
      4'd4:    atan_lut = 16'd256;
      4'd5:    atan_lut = 16'd128;
      4'd6:    atan_lut = 16'd64;
      4'd7:    atan_lut = 16'd32;
      4'd8:    atan_lut = 16'd16;
      4'd9:    atan_lut = 16'd8;
      4'd10:   atan_lut = 16'd4;
      4'd11:   atan_lut = 16'd2;
      4'd12:   atan_lut = 16'd1;
      default: atan_lut = 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/barrel_shifter.sv
// Arithmetic right barrel shifter: y_o = data_i >>> amount_i, sign-extending,
// built as four conditional power-of-two stages.
module barrel_shifter #(
  parameter int Width = 16
) (
  input  logic [Width-1:0] data_i,
  input  logic [3:0]       amount_i,
  output logic [Width-1:0] y_o
);

  logic [4:0][Width-1:0] stage;

  assign stage[0] = data_i;

  for (genvar s = 0; s < 4; s++) begin : g_stage
    localparam int SH = 1 << s;
    logic signed [Width-1:0] shifted;
    assign shifted      = $signed(stage[s]) >>> SH;
    assign stage[s+1]   = amount_i[s] ? shifted : stage[s];
  end

  assign y_o = stage[4];

endmodule

// File: rtl/cordic_iter_core.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, valid/ready in and out.
// Define CORDIC_GAIN_COMP_EN to add a SCALE state that multiplies x/y by 1/K.
module cordic_iter_core
  import cordic_pkg::*;
#(
  parameter int Width      = 16,
  parameter int Iterations = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] x_i,
  input  logic [Width-1:0] y_i,
  input  logic [Width-1:0] z_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] x_o,
  output logic [Width-1:0] y_o,
  output logic [Width-1:0] z_o
);

  localparam logic [3:0] LAST = 4'(Iterations - 1);

  state_t                  state, state_nx;
  logic [3:0]              cnt;
  logic signed [Width-1:0] x, y, z;
  logic signed [Width-1:0] xs, ys, atan;
  logic signed [Width-1:0] x_rot, y_rot, z_rot;
  logic                    neg;

  barrel_shifter #(.Width(Width)) u_shift_x (
    .data_i  (x),
    .amount_i(cnt),
    .y_o     (xs)
  );

  barrel_shifter #(.Width(Width)) u_shift_y (
    .data_i  (y),
    .amount_i(cnt),
    .y_o     (ys)
  );

  // z == 0 counts as positive, so only the sign bit steers the rotation
  assign neg   = z[Width-1];
  assign atan  = Width'(atan_lut(cnt));
  assign x_rot = neg ? (x + ys) : (x - ys);
  assign y_rot = neg ? (y - xs) : (y + xs);
  assign z_rot = neg ? (z + atan) : (z - atan);

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [2*Width-1:0] GAIN = (2*Width)'(INV_GAIN);
  localparam logic signed [2*Width-1:0] RND  = (2*Width)'(1 << (XY_FRAC - 1));
  logic signed [2*Width-1:0] px, py;
  logic signed [Width-1:0]   x_sc, y_sc;

  assign px   = x * GAIN;
  assign py   = y * GAIN;
  assign x_sc = Width'((px + RND) >>> XY_FRAC);
  assign y_sc = Width'((py + RND) >>> XY_FRAC);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready_o  = 1'b0;
    valid_o  = 1'b0;
    case (state)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (valid_i) state_nx = ST_ROTATE;
      end
      ST_ROTATE: begin
`ifdef CORDIC_GAIN_COMP_EN
        if (cnt == LAST) state_nx = ST_SCALE;
`else
        if (cnt == LAST) state_nx = ST_DONE;
`endif
      end
      ST_SCALE: state_nx = ST_DONE;
      ST_DONE: begin
        valid_o = 1'b1;
        if (ready_i) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x   <= '0;
      y   <= '0;
      z   <= '0;
      cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (valid_i) begin
            x   <= x_i;
            y   <= y_i;
            z   <= z_i;
            cnt <= '0;
          end
        end
        ST_ROTATE: begin
          x   <= x_rot;
          y   <= y_rot;
          z   <= z_rot;
          cnt <= cnt + 4'd1;
        end
`ifdef CORDIC_GAIN_COMP_EN
        ST_SCALE: begin
          x <= x_sc;
          y <= y_sc;
        end
`endif
        default: ;
      endcase
    end
  end

  assign x_o = x;
  assign y_o = y;
  assign z_o = z;

endmodule

// File: tb/tb_cordic_iter_core.sv
// Self-checking bench for cordic_iter_core: integer CORDIC reference model, scoreboard
// compare on every negedge, directed trigonometric sanity points and random operations.
module tb_cordic_iter_core;

  localparam int W    = 16;
  localparam int ITER = 16;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT  = ITER + 1;
  localparam int X0   = 8192;
`else
  localparam int LAT  = ITER;
  localparam int X0   = 4975;
`endif

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b1;
  logic                valid_i = 1'b0;
  logic                ready_o;
  logic signed [W-1:0] x_i = '0, y_i = '0, z_i = '0;
  logic                valid_o;
  logic                ready_i = 1'b0;
  logic signed [W-1:0] x_o, y_o, z_o;

  cordic_iter_core #(.Width(W), .Iterations(ITER)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .x_i    (x_i),
    .y_i    (y_i),
    .z_i    (z_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .x_o    (x_o),
    .y_o    (y_o),
    .z_o    (z_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int x;
    int y;
    int z;
    int acc;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_pop = -100;
  bit   b2b_chk = 1'b0;
  bit   prev_valid = 1'b0;
  int   atan_tab[ITER];
  exp_t q[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic chk_near(input string name, input int got, input int want, input int tol);
    checks++;
    if (got > want + tol || got < want - tol) begin
      errors++;
      $display("FAIL %s got %0d expected %0d +/- %0d", name, got, want, tol);
    end
  endtask

  function automatic int wrap(input int v);
    logic signed [W-1:0] t;
    t = v[W-1:0];
    return int'(t);
  endfunction

  // Reference: plain integer rotation-mode CORDIC with angles taken from real atan()
  function automatic exp_t model(input int x0, input int y0, input int z0);
    exp_t r;
    int x = x0, y = y0, z = z0, xn, yn, zn;
    for (int i = 0; i < ITER; i++) begin
      if (z >= 0) begin
        xn = x - (y >>> i); yn = y + (x >>> i); zn = z - atan_tab[i];
      end else begin
        xn = x + (y >>> i); yn = y - (x >>> i); zn = z + atan_tab[i];
      end
      x = wrap(xn); y = wrap(yn); z = wrap(zn);
    end
`ifdef CORDIC_GAIN_COMP_EN
    x = wrap((x * 4975 + 4096) >>> 13);
    y = wrap((y * 4975 + 4096) >>> 13);
`endif
    r.x = x; r.y = y; r.z = z; r.acc = 0;
    return r;
  endfunction

  // Single compare process: scoreboard, latency, reset state, handshakes
  always @(negedge clk_i) begin
    if (rst_i) begin
      q.delete();
      prev_valid = 1'b0;
      chk("rst_valid_o", int'(valid_o), 0);
      chk("rst_ready_o", int'(ready_o), 1);
      chk("rst_x_o", int'(x_o), 0);
      chk("rst_y_o", int'(y_o), 0);
      chk("rst_z_o", int'(z_o), 0);
    end else begin
      if (valid_o) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          chk("res_x", int'(x_o), q[0].x);
          chk("res_y", int'(y_o), q[0].y);
          chk("res_z", int'(z_o), q[0].z);
          chk("busy_ready_o", int'(ready_o), 0);
          if (!prev_valid) chk("latency", cyc - q[0].acc, LAT);
          if (ready_i) begin
            void'(q.pop_front());
            last_pop = cyc + 1;
          end
        end
      end
      if (valid_i && ready_o) begin
        exp_t e;
        e = model(int'(x_i), int'(y_i), int'(z_i));
        e.acc = cyc + 1;
        if (b2b_chk) chk("b2b_gap", e.acc, last_pop + 1);
        q.push_back(e);
      end
      prev_valid = valid_o;
    end
  end

  task automatic send(input int x, input int y, input int z, input bit keep);
    bit ok = 1'b0;
    valid_i = 1'b1; x_i = W'(x); y_i = W'(y); z_i = W'(z);
    for (int n = 0; n < 100; n++) begin
      if (ready_o) begin
        @(posedge clk_i); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk_i); #1;
    end
    if (!keep) valid_i = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_valid();
    bit ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (valid_o) begin ok = 1'b1; break; end
      @(posedge clk_i); #1;
    end
    if (!ok) chk("valid_timeout", 0, 1);
  endtask

  task automatic recv(input int stall, output int rx, output int ry, output int rz);
    wait_valid();
    rx = int'(x_o); ry = int'(y_o); rz = int'(z_o);
    repeat (stall) begin @(posedge clk_i); #1; end
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    chk("post_hs_ready_o", int'(ready_o), 1);
    chk("post_hs_valid_o", int'(valid_o), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int rx, ry, rz;
    real p;
    p = 1.0;
    for (int i = 0; i < ITER; i++) begin
      atan_tab[i] = $rtoi($atan(p) * 4096.0 + 0.5);
      p = p / 2.0;
    end

    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Directed points against known trigonometric values
    send(X0, 0, 0, 1'b0);
    recv(0, rx, ry, rz);
    chk_near("id_x", rx, 8192, 16);
    chk_near("id_y", ry, 0, 16);
    chk_near("id_z", rz, 0, 2);

    send(X0, 0, 3217, 1'b0);
    recv(2, rx, ry, rz);
    chk_near("pi4_x", rx, 5793, 16);
    chk_near("pi4_y", ry, 5793, 16);

    send(X0, 0, -4289, 1'b0);
    recv(1, rx, ry, rz);
    chk_near("neg60_x", rx, 4096, 16);
    chk_near("neg60_y", ry, -7094, 16);

    // Backpressure: outputs held for 10 cycles, stray valid_i ignored
    send(3000, -2000, 1500, 1'b0);
    wait_valid();
    for (int k = 0; k < 10; k++) begin
      @(posedge clk_i); #1;
      if (k == 3) begin valid_i = 1'b1; x_i = W'(1234); end
      if (k == 6) valid_i = 1'b0;
      chk("bp_ready_o", int'(ready_o), 0);
      chk("bp_valid_o", int'(valid_o), 1);
    end
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    chk("bp_release_ready_o", int'(ready_o), 1);
    chk("bp_release_valid_o", int'(valid_o), 0);

    // Back-to-back with valid_i held high
    ready_i = 1'b1;
    send(-5000, 4000, 2000, 1'b1);
    x_i = W'(6000); y_i = W'(-3000); z_i = W'(-6000);
    b2b_chk = 1'b1;
    for (int n = 0; n < 100 && !ready_o; n++) begin @(posedge clk_i); #1; end
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    chk("b2b_second_accepted", int'(ready_o), 0);
    wait_valid();
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    b2b_chk = 1'b0;

    // Reset during iteration 7 aborts with no result
    send(7000, 1000, 5000, 1'b0);
    repeat (7) @(posedge clk_i);
    #1 rst_i = 1'b1;
    #1;
    chk("midrst_valid_o", int'(valid_o), 0);
    chk("midrst_ready_o", int'(ready_o), 1);
    chk("midrst_x_o", int'(x_o), 0);
    @(posedge clk_i); #1 rst_i = 1'b0;

    // Random operations within the convergence/range envelope
    for (int n = 0; n < 40; n++) begin
      send($urandom_range(19660) - 9830, $urandom_range(19660) - 9830,
           $urandom_range(14254) - 7127, 1'b0);
      recv($urandom_range(3), rx, ry, rz);
    end

    repeat (3) @(posedge clk_i);
    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_iter_core.md
Name: cordic_iter_core

Overview:
- Iterative rotation-mode CORDIC engine: one micro-rotation per clock, reusing two barrel_shifter instances for the x>>>i and y>>>i terms.
- Sits directly upstream of barrel_shifter:
  - drives amount_i with the iteration index;
  - consumes y_o in its add/sub datapath.
- Accepts (x, y, z) through a valid/ready handshake and returns the rotated vector plus residual angle through a valid/ready handshake.

Parameters:
- Width, 16, datapath width of x/y/z; must be ≥ Iterations.
- Iterations, 16, micro-rotations per operation; range 1..16, limited by the 4-bit shift amount.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- valid_i  in  1  input operands valid.
- ready_o  out  1  core can accept operands (high only in IDLE).
- x_i  in  Width  signed x, Q2.13.
- y_i  in  Width  signed y, Q2.13.
- z_i  in  Width  signed angle, radians, Q3.12.
- valid_o  out  1  results valid.
- ready_i  in  1  downstream accepts results.
- x_o  out  Width  rotated x, Q2.13.
- y_o  out  Width  rotated y, Q2.13.
- z_o  out  Width  residual angle, Q3.12.

Behaviour:
- Reset: async assert forces state IDLE, iteration counter 0, x/y/z registers 0, valid_o 0, ready_o 1 after reset. Reset mid-operation aborts the operation with no output produced.
- FSM states:
  - IDLE: ready_o=1.
    - Exit: valid_i&ready_o at an edge loads x_i/y_i/z_i, clears the counter, goes to ROTATE.
  - ROTATE: ready_o=0.
    - Each edge performs iteration i = counter: d = (z ≥ 0) ? +1 : −1;
      - x' = x − d·(y>>>i);
      - y' = y + d·(x>>>i);
      - z' = z − d·ATAN_LUT[i].
    - Exit: after iteration Iterations−1, go to DONE.
  - DONE: valid_o=1; outputs held stable while ready_i=0.
    - Exit: valid_o&ready_i at an edge goes to IDLE.
- Latency: valid_o rises exactly Iterations cycles after the accepting edge. No new operand is accepted in the cycle results are consumed; throughput is 1 op per Iterations+2 cycles.
- Shifts: arithmetic (sign-extending) via barrel_shifter, truncation toward −∞, no rounding.
- Arithmetic: Width-bit two's complement, wrap-around on overflow, no saturation.
  - Caller keeps |x|,|y| ≤ 1.2 to keep results within Q2.13 range after gain K≈1.6468.
  - Caller keeps |z| ≤ 1.74 rad, the convergence range.
- z = 0 is treated as positive (d=+1).
- valid_i while busy: ignored; ready_o low, so there is no accept.
- Outputs x_o/y_o/z_o: reflect the working registers; only meaningful while valid_o=1.

Optional Feature:
- Macro CORDIC_GAIN_COMP_EN.
- Defined:
  - Extra state SCALE between ROTATE and DONE multiplies x and y by INV_GAIN (4975 = 0.60725 in Q2.13).
  - The product is rounded half-up and truncated back to Q2.13.
  - Latency becomes Iterations+1.
- Undefined: outputs carry gain K; latency Iterations; no multiplier is synthesized.

Decomposition:
- Package cordic_pkg holds:
  - the FSM state enum;
  - ATAN_LUT: 16 entries in Q3.12, round(atan(2^-i)·4096) = 3217, 1899, 1003, 509, 256, 128, 64, 32, 16, 8, 4, 2, 1, 0, 0, 0;
  - INV_GAIN constant;
  - Q-format constants.
- Sub-module: barrel_shifter, instantiated twice (x path, y path) with amount_i = counter. No other sub-modules.

Test Plan:
- Identity rotation: x=4975, y=0, z=0, no gain comp → x_o≈8192±16, y_o≈0±16, |z_o|≤2; valid_o exactly 16 cycles after accept.
- π/4 rotation: x=4975, y=0, z=3217 → x_o≈y_o≈5793±16; with CORDIC_GAIN_COMP_EN and x=8192 → same results, valid_o at cycle 17.
- Negative angle: x=4975, y=0, z=−4289 (−π/3) → x_o≈4096±16, y_o≈−7094±16.
- Output backpressure: hold ready_i=0 for 10 cycles in DONE → valid_o and outputs stable, ready_o=0. Pulse valid_i during that window → no accept. Release ready_i → IDLE next edge, ready_o=1.
- Back-to-back: valid_i held high across two operations → second accept occurs exactly one cycle after result handshake; both results correct.
- Reset mid-op: assert rst_i at iteration 7 → valid_o=0, ready_o=1 immediately, outputs 0. A subsequent operation is unaffected.
